// File: rtl/mips_defs.sv
// Shared MIPS decode constants, stage timing classes and MD sequencer state
// encoding for the hazard controller and its decoders.
package mips_defs;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2a;

  localparam logic [4:0] RT_BGEZ = 5'd1;
  localparam logic [4:0] REG_RA  = 5'd31;

  // Larger than any Tnew, so an unused source can never stall.
  localparam logic [1:0] TUSE_INF = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  typedef enum logic [1:0] {
    TN_NONE = 2'd0,
    TN_ALU  = 2'd1,
    TN_LOAD = 2'd2,
    TN_LINK = 2'd3
  } tnew_cls_e;

  function automatic logic [1:0] tnew_in_e(input tnew_cls_e cls);
    logic [1:0] t;
    case (cls)
      TN_LOAD: t = 2'd2;
      TN_ALU:  t = 2'd1;
      TN_LINK: t = 2'd0;
      TN_NONE: t = 2'd0;
      default: t = 2'd0;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] tnew_in_m(input tnew_cls_e cls);
    logic [1:0] t;
    case (cls)
      TN_LOAD: t = 2'd1;
      default: t = 2'd0;
    endcase
    return t;
  endfunction

  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] dst, input logic [1:0] tnew);
    return (src != 5'd0) && (src == dst) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/md_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage instruction words in,
// stall/flush and HI/LO sequencer status out.
interface md_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  logic [31:0]      IR_D;
  logic [31:0]      IR_E;
  logic [31:0]      IR_M;
  logic             PC_En;
  logic             IF_ID_En;
  logic             IR_E_Clr;
  logic             MD_Start;
  logic             MD_Busy;
  logic [CNT_W-1:0] MD_Cnt;

  modport master (
    output IR_D, IR_E, IR_M,
    input  PC_En, IF_ID_En, IR_E_Clr, MD_Start, MD_Busy, MD_Cnt
  );

  modport slave (
    input  IR_D, IR_E, IR_M,
    output PC_En, IF_ID_En, IR_E_Clr, MD_Start, MD_Busy, MD_Cnt
  );
endinterface

// File: rtl/instr_class_decode.sv
// Per-stage instruction classifier: register fields actually read/written,
// operand use times, result timing class and HI/LO involvement.
module instr_class_decode
  import mips_defs::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  dest,
  output logic [1:0]  tuse_rs,
  output logic [1:0]  tuse_rt,
  output tnew_cls_e   tnew_cls,
  output logic        md_op,
  output logic        is_div,
  output logic        hilo_op
);

  logic [5:0] op_s;
  logic [5:0] funct_s;
  logic [4:0] rs_f_s;
  logic [4:0] rt_f_s;
  logic [4:0] rd_f_s;
  logic       unused_shamt_s;

  assign op_s           = ir[31:26];
  assign rs_f_s         = ir[25:21];
  assign rt_f_s         = ir[20:16];
  assign rd_f_s         = ir[15:11];
  assign funct_s        = ir[5:0];
  assign unused_shamt_s = ^ir[10:6];

  // Classify the word; anything unrecognised falls through as a nop.
  always_comb begin
    rs       = 5'd0;
    rt       = 5'd0;
    dest     = 5'd0;
    tuse_rs  = TUSE_INF;
    tuse_rt  = TUSE_INF;
    tnew_cls = TN_NONE;
    md_op    = 1'b0;
    is_div   = 1'b0;
    hilo_op  = 1'b0;
    case (op_s)
      OP_RTYPE: begin
        case (funct_s)
          F_ADDU, F_SUBU, F_AND, F_OR, F_SLT: begin
            rs = rs_f_s; tuse_rs = 2'd1;
            rt = rt_f_s; tuse_rt = 2'd1;
            dest = rd_f_s; tnew_cls = TN_ALU;
          end
          F_SLL, F_SRL: begin
            rt = rt_f_s; tuse_rt = 2'd1;
            dest = rd_f_s; tnew_cls = TN_ALU;
          end
          F_JR: begin
            rs = rs_f_s; tuse_rs = 2'd0;
          end
          F_JALR: begin
            rs = rs_f_s; tuse_rs = 2'd0;
            dest = rd_f_s; tnew_cls = TN_LINK;
          end
          F_MULT, F_MULTU: begin
            rs = rs_f_s; tuse_rs = 2'd1;
            rt = rt_f_s; tuse_rt = 2'd1;
            md_op = 1'b1; hilo_op = 1'b1;
          end
          F_DIV, F_DIVU: begin
            rs = rs_f_s; tuse_rs = 2'd1;
            rt = rt_f_s; tuse_rt = 2'd1;
            md_op = 1'b1; is_div = 1'b1; hilo_op = 1'b1;
          end
          F_MFHI, F_MFLO: begin
            dest = rd_f_s; tnew_cls = TN_ALU; hilo_op = 1'b1;
          end
          F_MTHI, F_MTLO: begin
            rs = rs_f_s; tuse_rs = 2'd1; hilo_op = 1'b1;
          end
          default: begin
            dest = 5'd0;
          end
        endcase
      end
      OP_ORI, OP_ADDIU: begin
        rs = rs_f_s; tuse_rs = 2'd1;
        dest = rt_f_s; tnew_cls = TN_ALU;
      end
      OP_LUI: begin
        dest = rt_f_s; tnew_cls = TN_ALU;
      end
      OP_LW: begin
        rs = rs_f_s; tuse_rs = 2'd1;
        dest = rt_f_s; tnew_cls = TN_LOAD;
      end
      OP_SW: begin
        rs = rs_f_s; tuse_rs = 2'd1;
        rt = rt_f_s; tuse_rt = 2'd2;
      end
      OP_BEQ, OP_BNE: begin
        rs = rs_f_s; tuse_rs = 2'd0;
        rt = rt_f_s; tuse_rt = 2'd0;
      end
      OP_REGIMM: begin
        if (rt_f_s == RT_BGEZ) begin
          rs = rs_f_s; tuse_rs = 2'd0;
        end else begin
          rs = 5'd0;
        end
      end
      OP_JAL: begin
        dest = REG_RA; tnew_cls = TN_LINK;
      end
      OP_J: begin
        dest = 5'd0;
      end
      default: begin
        dest = 5'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core plus the HI/LO busy sequencer
// that serialises mult/div traffic.
module md_hazard_ctrl
  import mips_defs::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input logic               Clk,
  input logic               Reset,
  md_hazard_ctrl_if.slave   bus
);

  logic [4:0] rs_d_s, rt_d_s, dest_d_s;
  logic [1:0] tuse_rs_d_s, tuse_rt_d_s;
  tnew_cls_e  cls_d_s;
  logic       md_op_d_s, is_div_d_s, hilo_op_d_s;

  logic [4:0] rs_e_s, rt_e_s, dest_e_s;
  logic [1:0] tuse_rs_e_s, tuse_rt_e_s;
  tnew_cls_e  cls_e_s;
  logic       md_op_e_s, is_div_e_s, hilo_op_e_s;

  logic [4:0] rs_m_s, rt_m_s, dest_m_s;
  logic [1:0] tuse_rs_m_s, tuse_rt_m_s;
  tnew_cls_e  cls_m_s;
  logic       md_op_m_s, is_div_m_s, hilo_op_m_s;

  logic [1:0] tnew_e_s, tnew_m_s;
  logic       data_stall_s, md_stall_s, stall_s, md_start_s;

  md_state_e        state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s, load_cnt_s;
  logic             busy_r, busy_nxt_s;
  logic             unused_s;

  instr_class_decode u_dec_d (
    .ir(bus.IR_D), .rs(rs_d_s), .rt(rt_d_s), .dest(dest_d_s),
    .tuse_rs(tuse_rs_d_s), .tuse_rt(tuse_rt_d_s), .tnew_cls(cls_d_s),
    .md_op(md_op_d_s), .is_div(is_div_d_s), .hilo_op(hilo_op_d_s)
  );

  instr_class_decode u_dec_e (
    .ir(bus.IR_E), .rs(rs_e_s), .rt(rt_e_s), .dest(dest_e_s),
    .tuse_rs(tuse_rs_e_s), .tuse_rt(tuse_rt_e_s), .tnew_cls(cls_e_s),
    .md_op(md_op_e_s), .is_div(is_div_e_s), .hilo_op(hilo_op_e_s)
  );

  instr_class_decode u_dec_m (
    .ir(bus.IR_M), .rs(rs_m_s), .rt(rt_m_s), .dest(dest_m_s),
    .tuse_rs(tuse_rs_m_s), .tuse_rt(tuse_rt_m_s), .tnew_cls(cls_m_s),
    .md_op(md_op_m_s), .is_div(is_div_m_s), .hilo_op(hilo_op_m_s)
  );

  assign unused_s = ^{dest_d_s, cls_d_s, md_op_d_s, is_div_d_s,
                      rs_e_s, rt_e_s, tuse_rs_e_s, tuse_rt_e_s, hilo_op_e_s,
                      rs_m_s, rt_m_s, tuse_rs_m_s, tuse_rt_m_s, cls_m_s == TN_NONE,
                      md_op_m_s, is_div_m_s, hilo_op_m_s};

  assign tnew_e_s = tnew_in_e(cls_e_s);
  assign tnew_m_s = tnew_in_m(cls_m_s);

  // Only a result that arrives later than its consumer needs it stalls; all else forwards.
  assign data_stall_s = src_hazard(rs_d_s, tuse_rs_d_s, dest_e_s, tnew_e_s)
                      | src_hazard(rs_d_s, tuse_rs_d_s, dest_m_s, tnew_m_s)
                      | src_hazard(rt_d_s, tuse_rt_d_s, dest_e_s, tnew_e_s)
                      | src_hazard(rt_d_s, tuse_rt_d_s, dest_m_s, tnew_m_s);

  assign md_start_s = md_op_e_s;
  assign md_stall_s = hilo_op_d_s & (busy_r | md_start_s);
  assign stall_s    = data_stall_s | md_stall_s;

  assign bus.PC_En    = ~stall_s;
  assign bus.IF_ID_En = ~stall_s;
  assign bus.IR_E_Clr = stall_s;
  assign bus.MD_Start = md_start_s;
  assign bus.MD_Busy  = busy_r;
  assign bus.MD_Cnt   = cnt_r;

  assign load_cnt_s = is_div_e_s ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // Sequencer state, count and busy flag registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Sequencer next state; a start while busy simply reloads the count.
  always_comb begin
    state_nxt_s = IDLE;
    cnt_nxt_s   = {CNT_W{1'b0}};
    busy_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (md_start_s) begin
          state_nxt_s = BUSY;
          cnt_nxt_s   = load_cnt_s;
          busy_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (md_start_s) begin
          state_nxt_s = BUSY;
          cnt_nxt_s   = load_cnt_s;
          busy_nxt_s  = 1'b1;
        end else if (cnt_r <= CNT_W'(1)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
          cnt_nxt_s   = cnt_r - CNT_W'(1);
          busy_nxt_s  = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Directed self-checking bench for md_hazard_ctrl: data hazards, zero-register
// rule, mult/div busy sequencing and asynchronous reset abort.
module tb_md_hazard_ctrl;

  localparam logic [31:0] LW_1     = 32'h8C01_0000; // lw   $1,0($0)
  localparam logic [31:0] ADDU_213 = 32'h0023_1021; // addu $2,$1,$3
  localparam logic [31:0] BEQ_10   = 32'h1020_0004; // beq  $1,$0
  localparam logic [31:0] ADDU_456 = 32'h00A6_2021; // addu $4,$5,$6
  localparam logic [31:0] ADDU_156 = 32'h00A6_0821; // addu $1,$5,$6
  localparam logic [31:0] SW_45    = 32'hACA4_0000; // sw   $4,0($5)
  localparam logic [31:0] LW_4     = 32'h8C04_0000; // lw   $4,0($0)
  localparam logic [31:0] MULT_12  = 32'h0022_0018; // mult $1,$2
  localparam logic [31:0] DIV_12   = 32'h0022_001A; // div  $1,$2
  localparam logic [31:0] MFLO_3   = 32'h0000_1812; // mflo $3
  localparam logic [31:0] LUI_0    = 32'h3C00_1234; // lui  $0,0x1234
  localparam logic [31:0] ORI_20   = 32'h3402_0005; // ori  $2,$0,5
  localparam logic [31:0] JAL_T    = 32'h0C00_0010; // jal
  localparam logic [31:0] JR_31    = 32'h03E0_0008; // jr   $31
  localparam logic [31:0] UNK_1    = 32'hFC01_0000; // unknown opcode, rt field 1
  localparam logic [31:0] JR_1     = 32'h0020_0008; // jr   $1

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_mis;

  md_hazard_ctrl_if #(.CNT_W(4)) bus_i ();

  md_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus_i)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // {PC_En, IF_ID_En, IR_E_Clr}: stall -> 001, run -> 110
  task automatic check_ctl(input string tag, input logic stall);
    check(tag, 32'({bus_i.PC_En, bus_i.IF_ID_En, bus_i.IR_E_Clr}),
          stall ? 32'h1 : 32'h6);
  endtask

  task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
    @(posedge Clk);
    #1;
    bus_i.IR_D = d;
    bus_i.IR_E = e;
    bus_i.IR_M = m;
    @(negedge Clk);
  endtask

  // A start while the HI/LO unit is busy must never be produced.
  always @(negedge Clk) begin
    if (!Reset) check("start_while_busy", 32'(bus_i.MD_Start & bus_i.MD_Busy), 32'h0);
  end

  initial begin
    n_cmp = 0;
    n_mis = 0;
    Reset = 1'b1;
    bus_i.IR_D = 32'h0;
    bus_i.IR_E = 32'h0;
    bus_i.IR_M = 32'h0;
    #12;
    check_ctl("reset_ctl", 1'b0);
    check("reset_start", 32'(bus_i.MD_Start), 32'h0);
    check("reset_busy", 32'(bus_i.MD_Busy), 32'h0);
    check("reset_cnt", 32'(bus_i.MD_Cnt), 32'h0);
    Reset = 1'b0;

    drive(ADDU_213, LW_1, 32'h0);   check_ctl("lw_e_addu", 1'b1);
    drive(ADDU_213, 32'h0, LW_1);   check_ctl("lw_m_addu", 1'b0);

    drive(BEQ_10, LW_1, 32'h0);     check_ctl("lw_e_beq", 1'b1);
    drive(BEQ_10, 32'h0, LW_1);     check_ctl("lw_m_beq", 1'b1);
    drive(BEQ_10, 32'h0, 32'h0);    check_ctl("beq_free", 1'b0);
    drive(BEQ_10, ADDU_156, 32'h0); check_ctl("alu_e_beq", 1'b1);

    drive(SW_45, ADDU_456, 32'h0);  check_ctl("alu_e_sw", 1'b0);
    drive(SW_45, LW_4, 32'h0);      check_ctl("lw_e_sw", 1'b0);
    drive(SW_45, 32'h0, LW_4);      check_ctl("lw_m_sw", 1'b0);

    drive(ORI_20, LUI_0, 32'h0);    check_ctl("zero_reg", 1'b0);
    drive(JR_31, JAL_T, 32'h0);     check_ctl("jal_jr", 1'b0);
    drive(JR_31, 32'h0, JAL_T);     check_ctl("jal_m_jr", 1'b0);
    drive(JR_1, UNK_1, 32'h0);      check_ctl("unknown_nop", 1'b0);

    // mult with dependent mflo held in D
    drive(MFLO_3, MULT_12, 32'h0);
    check("mult_start", 32'(bus_i.MD_Start), 32'h1);
    check("mult_busy0", 32'(bus_i.MD_Busy), 32'h0);
    check_ctl("mult_mflo_stall0", 1'b1);
    for (int k = 5; k >= 1; k--) begin
      drive(MFLO_3, 32'h0, 32'h0);
      check("mult_busy", 32'(bus_i.MD_Busy), 32'h1);
      check("mult_cnt", 32'(bus_i.MD_Cnt), 32'(k));
      check("mult_nostart", 32'(bus_i.MD_Start), 32'h0);
      check_ctl("mult_mflo_stall", 1'b1);
    end
    drive(MFLO_3, 32'h0, 32'h0);
    check("mult_done_busy", 32'(bus_i.MD_Busy), 32'h0);
    check("mult_done_cnt", 32'(bus_i.MD_Cnt), 32'h0);
    check_ctl("mult_mflo_release", 1'b0);

    drive(32'h0, DIV_12, 32'h0);
    check("div_start", 32'(bus_i.MD_Start), 32'h1);
    for (int k = 10; k >= 1; k--) begin
      drive(32'h0, 32'h0, 32'h0);
      check("div_busy", 32'(bus_i.MD_Busy), 32'h1);
      check("div_cnt", 32'(bus_i.MD_Cnt), 32'(k));
    end
    drive(32'h0, 32'h0, 32'h0);
    check("div_done_busy", 32'(bus_i.MD_Busy), 32'h0);
    check("div_done_cnt", 32'(bus_i.MD_Cnt), 32'h0);

    // div aborted by reset at count 6, between clock edges
    drive(32'h0, DIV_12, 32'h0);
    for (int k = 0; k < 5; k++) drive(32'h0, 32'h0, 32'h0);
    check("abort_pre_cnt", 32'(bus_i.MD_Cnt), 32'h6);
    #1;
    Reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus_i.MD_Busy), 32'h0);
    check("abort_cnt", 32'(bus_i.MD_Cnt), 32'h0);
    #1;
    Reset = 1'b0;
    drive(MFLO_3, 32'h0, 32'h0);
    check("abort_idle_busy", 32'(bus_i.MD_Busy), 32'h0);
    check_ctl("abort_mflo_free", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
